// File: rtl/i2cmb_pkg.sv
// Shared register map, command codes and status encodings for the iicmb command sequencer.
package i2cmb_pkg;

    typedef enum logic [1:0] {
        RegCsr  = 2'd0,
        RegDpr  = 2'd1,
        RegCmdr = 2'd2
    } reg_addr_e;

    typedef enum logic [2:0] {
        CmdWrite  = 3'b001,
        CmdRdAck  = 3'b010,
        CmdRdNack = 3'b011,
        CmdStart  = 3'b100,
        CmdStop   = 3'b101,
        CmdSetBus = 3'b110
    } cmd_code_e;

    typedef enum logic [1:0] {
        StatOk      = 2'b00,
        StatNack    = 2'b01,
        StatArbLost = 2'b10,
        StatErr     = 2'b11
    } status_e;

    localparam int unsigned CmdrDon = 7;
    localparam int unsigned CmdrNak = 6;
    localparam int unsigned CmdrAl  = 5;
    localparam int unsigned CmdrErr = 4;

    localparam logic [7:0] CsrEnable = 8'hC0;

    function automatic logic [7:0] cmdr_byte(input cmd_code_e code);
        return {5'b00000, code};
    endfunction

endpackage

// File: rtl/wb_single_xfer.sv
// One classic Wishbone single read or write; holds cyc/stb with stable adr/we/dat until ack.
module wb_single_xfer #(
    parameter int unsigned WB_ADDR_WIDTH = 2,
    parameter int unsigned WB_DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     we,
    input  logic [WB_ADDR_WIDTH-1:0] adr,
    input  logic [WB_DATA_WIDTH-1:0] wdata,
    output logic                     busy,
    output logic                     done,
    output logic [WB_DATA_WIDTH-1:0] rdata,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i
);

    logic                     cyc_q;
    logic                     we_q;
    logic                     done_q;
    logic [WB_ADDR_WIDTH-1:0] adr_q;
    logic [WB_DATA_WIDTH-1:0] dat_q;
    logic [WB_DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (cyc_q) begin
                if (ack_i) begin
                    cyc_q  <= 1'b0;
                    done_q <= 1'b1;
                    if (!we_q) begin
                        rdata_q <= dat_i;
                    end
                end
            end else if (start) begin
                cyc_q <= 1'b1;
                we_q  <= we;
                adr_q <= adr;
                dat_q <= wdata;
            end
        end
    end

    assign cyc_o = cyc_q;
    assign stb_o = cyc_q;
    assign we_o  = we_q;
    assign adr_o = adr_q;
    assign dat_o = dat_q;
    assign busy  = cyc_q;
    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: rtl/i2cmb_cmd_sequencer.sv
// Wishbone master that expands one I2C transaction request into the iicmb CSR/DPR/CMDR sequence.
module i2cmb_cmd_sequencer
    import i2cmb_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH = 2,
    parameter int unsigned WB_DATA_WIDTH = 8,
    parameter int unsigned IRQ_TIMEOUT   = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_bus,
    input  logic [6:0]               req_addr,
    input  logic                     req_rd,
    input  logic [7:0]               req_len,
    input  logic [7:0]               wdata,
    input  logic                     wdata_valid,
    output logic                     wdata_ready,
    output logic [7:0]               rdata,
    output logic                     rdata_valid,
    input  logic                     rdata_ready,
    output logic                     done,
    output logic [1:0]               status,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq
);

    typedef enum logic [3:0] {
        StInit, StInitWait, StIdle, StDpr, StDprWait, StCmd, StCmdWait, StIrq,
        StStat, StStatWait, StRdDpr, StRdDprWait, StRdHold, StDone
    } state_e;

    typedef enum logic [2:0] {
        StepSetBus, StepStart, StepAddr, StepWr, StepRd, StepStop
    } step_e;

    localparam int unsigned TmoW = (IRQ_TIMEOUT > 1) ? $clog2(IRQ_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(IRQ_TIMEOUT - 1);

    state_e            state_q, state_d;
    step_e             step_q, step_d;
    status_e           status_q, status_d;
    logic [3:0]        bus_q, bus_d;
    logic [6:0]        addr_q, addr_d;
    logic              rd_q, rd_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;

    logic                     xfer_start;
    logic                     xfer_we;
    logic [WB_ADDR_WIDTH-1:0] xfer_adr;
    logic [WB_DATA_WIDTH-1:0] xfer_wdata;
    logic                     xfer_busy;
    logic                     xfer_done;
    logic [WB_DATA_WIDTH-1:0] xfer_rdata;

    logic       fault;
    logic       timeout_hit;
    logic [7:0] stat_byte;
    cmd_code_e  cmd;

    wb_single_xfer #(
        .WB_ADDR_WIDTH(WB_ADDR_WIDTH),
        .WB_DATA_WIDTH(WB_DATA_WIDTH)
    ) u_xfer (
        .clk   (clk),
        .rst   (rst),
        .start (xfer_start),
        .we    (xfer_we),
        .adr   (xfer_adr),
        .wdata (xfer_wdata),
        .busy  (xfer_busy),
        .done  (xfer_done),
        .rdata (xfer_rdata),
        .cyc_o (cyc_o),
        .stb_o (stb_o),
        .we_o  (we_o),
        .adr_o (adr_o),
        .dat_o (dat_o),
        .dat_i (dat_i),
        .ack_i (ack_i)
    );

    // A zero timeout lets the counter free-run without ever matching.
    assign timeout_hit = (IRQ_TIMEOUT != 0) && (tmo_q == TmoLast);
    assign stat_byte   = xfer_rdata[7:0];

    always_comb begin
        case (step_q)
            StepSetBus: cmd = CmdSetBus;
            StepStart:  cmd = CmdStart;
            StepRd:     cmd = (count_q == 8'd1) ? CmdRdNack : CmdRdAck;
            StepStop:   cmd = CmdStop;
            default:    cmd = CmdWrite;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        status_d    = status_q;
        bus_d       = bus_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        tmo_d       = tmo_q;
        xfer_start  = 1'b0;
        xfer_we     = 1'b1;
        xfer_adr    = WB_ADDR_WIDTH'(RegCsr);
        xfer_wdata  = '0;
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;

        unique case (state_q)
            StInit: begin
                xfer_wdata = WB_DATA_WIDTH'(CsrEnable);
                if (!xfer_busy) begin
                    xfer_start = 1'b1;
                    state_d    = StInitWait;
                end
            end
            StInitWait: if (xfer_done) state_d = StIdle;
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    bus_d    = req_bus;
                    addr_d   = req_addr;
                    rd_d     = req_rd;
                    count_d  = req_len;
                    status_d = StatOk;
                    step_d   = StepSetBus;
                    state_d  = StDpr;
                end
            end
            StDpr: begin
                xfer_adr = WB_ADDR_WIDTH'(RegDpr);
                case (step_q)
                    StepSetBus: xfer_wdata = WB_DATA_WIDTH'({4'b0000, bus_q});
                    StepAddr:   xfer_wdata = WB_DATA_WIDTH'({addr_q, rd_q});
                    default:    xfer_wdata = WB_DATA_WIDTH'(wdata);
                endcase
                if (!xfer_busy && (step_q != StepWr || wdata_valid)) begin
                    xfer_start  = 1'b1;
                    wdata_ready = (step_q == StepWr);
                    state_d     = StDprWait;
                end
            end
            StDprWait: if (xfer_done) state_d = StCmd;
            StCmd: begin
                xfer_adr   = WB_ADDR_WIDTH'(RegCmdr);
                xfer_wdata = WB_DATA_WIDTH'(cmdr_byte(cmd));
                tmo_d      = '0;
                if (!xfer_busy) begin
                    xfer_start = 1'b1;
                    state_d    = StCmdWait;
                end
            end
            StCmdWait: if (xfer_done) state_d = StIrq;
            StIrq: begin
                if (irq) begin
                    state_d = StStat;
                end else if (timeout_hit) begin
                    fault = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StStat: begin
                xfer_we  = 1'b0;
                xfer_adr = WB_ADDR_WIDTH'(RegCmdr);
                if (!xfer_busy) begin
                    xfer_start = 1'b1;
                    state_d    = StStatWait;
                end
            end
            StStatWait: begin
                if (xfer_done) begin
                    if (stat_byte[CmdrAl]) begin
                        // Controller already released the bus, so no STOP.
                        status_d = StatArbLost;
                        state_d  = StDone;
                    end else if (stat_byte[CmdrErr] || !(stat_byte[CmdrNak] || stat_byte[CmdrDon])) begin
                        fault = 1'b1;
                    end else if (stat_byte[CmdrNak] && (step_q == StepAddr || step_q == StepWr)) begin
                        status_d = StatNack;
                        step_d   = StepStop;
                        state_d  = StCmd;
                    end else begin
                        case (step_q)
                            StepSetBus: begin
                                step_d  = StepStart;
                                state_d = StCmd;
                            end
                            StepStart: begin
                                step_d  = StepAddr;
                                state_d = StDpr;
                            end
                            StepAddr: begin
                                if (count_q == 8'd0) begin
                                    step_d  = StepStop;
                                    state_d = StCmd;
                                end else if (rd_q) begin
                                    step_d  = StepRd;
                                    state_d = StCmd;
                                end else begin
                                    step_d  = StepWr;
                                    state_d = StDpr;
                                end
                            end
                            StepWr: begin
                                count_d = count_q - 8'd1;
                                if (count_q == 8'd1) begin
                                    step_d  = StepStop;
                                    state_d = StCmd;
                                end else begin
                                    state_d = StDpr;
                                end
                            end
                            StepRd:  state_d = StRdDpr;
                            default: state_d = StDone;
                        endcase
                    end
                end
            end
            StRdDpr: begin
                xfer_we  = 1'b0;
                xfer_adr = WB_ADDR_WIDTH'(RegDpr);
                if (!xfer_busy) begin
                    xfer_start = 1'b1;
                    state_d    = StRdDprWait;
                end
            end
            StRdDprWait: begin
                if (xfer_done) begin
                    rdata_d = xfer_rdata[7:0];
                    state_d = StRdHold;
                end
            end
            StRdHold: begin
                rdata_valid = 1'b1;
                if (rdata_ready) begin
                    count_d = count_q - 8'd1;
                    state_d = StCmd;
                    if (count_q == 8'd1) step_d = StepStop;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase

        // One STOP attempt after a fault; a fault during STOP itself ends the transaction.
        if (fault) begin
            status_d = StatErr;
            if (step_q == StepStop) begin
                state_d = StDone;
            end else begin
                step_d  = StepStop;
                state_d = StCmd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StInit;
            step_q   <= StepSetBus;
            status_q <= StatOk;
            bus_q    <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            count_q  <= '0;
            rdata_q  <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            status_q <= status_d;
            bus_q    <= bus_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            tmo_q    <= tmo_d;
        end
    end

    assign status = status_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Bench: Wishbone model of the iicmb controller plus one I2C slave at 0x12, checked against
// expected command/byte lists derived from the transaction request.
module tb_i2cmb_cmd_sequencer;

    localparam logic [2:0] CWrite = 3'b001, CRdAck = 3'b010, CRdNack = 3'b011;
    localparam logic [2:0] CStart = 3'b100, CStop = 3'b101, CSetBus = 3'b110;
    localparam logic [6:0] SlaveAddr = 7'h12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_bus = '0;
    logic [6:0] req_addr = '0;
    logic       req_rd = 1'b0;
    logic [7:0] req_len = '0;
    logic [7:0] wdata = '0;
    logic       wdata_valid = 1'b0;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       rdata_ready = 1'b0;
    logic       done;
    logic [1:0] status;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic [7:0] dat_i;
    logic       ack_i;
    logic       irq;

    i2cmb_cmd_sequencer #(
        .WB_ADDR_WIDTH(2),
        .WB_DATA_WIDTH(8),
        .IRQ_TIMEOUT  (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_bus    (req_bus),
        .req_addr   (req_addr),
        .req_rd     (req_rd),
        .req_len    (req_len),
        .wdata      (wdata),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .rdata_ready(rdata_ready),
        .done       (done),
        .status     (status),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .dat_i      (dat_i),
        .ack_i      (ack_i),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail = 0;

    // Controller/slave model state and observation logs.
    logic [2:0] cmd_log[$];
    logic [7:0] wr_log[$], rd_log[$], bus_log[$], addr_log[$], slave_q[$], wq[$];
    logic [2:0] exp_cmd[$];
    logic [7:0] tx_data[$];
    logic [7:0] dpr_w, dpr_r, cmdr_stat, csr_last;
    int         csr_writes = 0;
    int         irq_cnt = 0;
    bit         addr_phase = 0;
    bit         irq_en = 1;
    bit         wpop = 0;
    int         wr_pulses = 0;
    int         stall_left = 0;
    int         stall_seen = 0;

    task automatic do_cmd(input logic [2:0] c);
        cmd_log.push_back(c);
        cmdr_stat = 8'h80;
        case (c)
            CSetBus: bus_log.push_back(dpr_w);
            CStart:  addr_phase = 1;
            CWrite: begin
                if (addr_phase) begin
                    addr_phase = 0;
                    addr_log.push_back(dpr_w);
                    if (dpr_w[7:1] != SlaveAddr) cmdr_stat = 8'h40;
                end else begin
                    wr_log.push_back(dpr_w);
                end
            end
            CRdAck, CRdNack: dpr_r = (slave_q.size() != 0) ? slave_q.pop_front() : 8'hEE;
            CStop: addr_phase = 0;
            default: cmdr_stat = 8'h10;
        endcase
        irq_cnt = int'($urandom_range(1, 6));
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_i <= 1'b0;
            irq   <= 1'b0;
            dat_i <= '0;
            irq_cnt = 0;
            addr_phase = 0;
        end else begin
            if (irq_cnt != 0) begin
                irq_cnt = irq_cnt - 1;
                if (irq_cnt == 0 && irq_en) irq <= 1'b1;
            end
            if (cyc_o && stb_o && !ack_i) begin
                ack_i <= 1'b1;
                if (we_o) begin
                    case (adr_o)
                        2'd0: begin csr_writes++; csr_last = dat_o; end
                        2'd1: dpr_w = dat_o;
                        2'd2: do_cmd(dat_o[2:0]);
                        default: ;
                    endcase
                end else if (adr_o == 2'd2) begin
                    dat_i <= cmdr_stat;
                    irq   <= 1'b0;
                end else begin
                    dat_i <= (adr_o == 2'd1) ? dpr_r : 8'h00;
                end
            end else begin
                ack_i <= 1'b0;
            end
        end
    end

    // Write-byte source and read-byte sink; a byte handshaken at a negedge moves at the next posedge.
    always @(negedge clk) begin
        if (wpop && wq.size() != 0) void'(wq.pop_front());
        wpop = wdata_valid && wdata_ready;
        if (wpop) wr_pulses++;
        wdata_valid = (wq.size() != 0);
        wdata = (wq.size() != 0) ? wq[0] : 8'h00;

        if (rdata_valid) begin
            if (stall_left != 0) begin
                rdata_ready = 1'b0;
                stall_left--;
                stall_seen++;
            end else begin
                rdata_ready = ($urandom_range(0, 2) != 0);
                if (rdata_ready) rd_log.push_back(rdata);
            end
        end else begin
            rdata_ready = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int budget);
        int c = 0;
        while (req_ready !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("req_ready_seen", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic issue_req(input logic [3:0] bus, input logic [6:0] addr, input bit rd,
                             input int len);
        cmd_log.delete(); wr_log.delete(); rd_log.delete(); bus_log.delete(); addr_log.delete();
        wr_pulses = 0;
        stall_seen = 0;
        if (rd) slave_q = tx_data; else wq = tx_data;
        wait_ready(200);
        req_bus = bus; req_addr = addr; req_rd = rd; req_len = 8'(len);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("done_seen", {31'b0, done}, 32'd1);
    endtask

    // Expected command stream follows from the request alone.
    task automatic build_exp(input bit rd, input int len, input bit present);
        exp_cmd.delete();
        exp_cmd.push_back(CSetBus);
        exp_cmd.push_back(CStart);
        exp_cmd.push_back(CWrite);
        if (present) begin
            for (int i = 0; i < len; i++) begin
                exp_cmd.push_back(rd ? ((i == len - 1) ? CRdNack : CRdAck) : CWrite);
            end
        end
        exp_cmd.push_back(CStop);
    endtask

    task automatic check_cmds(input string name);
        check({name, ":cmd_count"}, cmd_log.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size() && i < cmd_log.size(); i++) begin
            check($sformatf("%s:cmd[%0d]", name, i), {29'b0, cmd_log[i]}, {29'b0, exp_cmd[i]});
        end
    endtask

    task automatic run_txn(input string name, input logic [3:0] bus, input logic [6:0] addr,
                           input bit rd, input int len);
        int  cyc;
        bit  present = (addr == SlaveAddr);
        issue_req(bus, addr, rd, len);
        wait_done(20000, cyc);
        check({name, ":status"}, {30'b0, status}, present ? 32'd0 : 32'd1);
        build_exp(rd, len, present);
        check_cmds(name);
        check({name, ":bus_count"}, bus_log.size(), 32'd1);
        if (bus_log.size() != 0) check({name, ":bus"}, {24'b0, bus_log[0]}, {28'b0, bus});
        check({name, ":addr_count"}, addr_log.size(), 32'd1);
        if (addr_log.size() != 0) check({name, ":addr"}, {24'b0, addr_log[0]}, {24'b0, addr, rd});
        if (!rd) begin
            check({name, ":wdata_ready_pulses"}, wr_pulses, present ? len : 0);
            check({name, ":wr_count"}, wr_log.size(), present ? len : 0);
            for (int i = 0; i < wr_log.size() && i < tx_data.size(); i++)
                check($sformatf("%s:wr[%0d]", name, i), {24'b0, wr_log[i]}, {24'b0, tx_data[i]});
        end else begin
            check({name, ":rd_count"}, rd_log.size(), present ? len : 0);
            for (int i = 0; i < rd_log.size() && i < tx_data.size(); i++)
                check($sformatf("%s:rd[%0d]", name, i), {24'b0, rd_log[i]}, {24'b0, tx_data[i]});
        end
        @(negedge clk);
        wq.delete();
        slave_q.delete();
    endtask

    task automatic fill_random(input int len);
        tx_data.delete();
        for (int i = 0; i < len; i++) tx_data.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int  cyc;
        int  prior;
        int  len;
        bit  rd;
        bit  found;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst:cyc_o", {31'b0, cyc_o}, 32'd0);
        check("rst:req_ready", {31'b0, req_ready}, 32'd0);
        check("rst:done", {31'b0, done}, 32'd0);
        check("rst:status", {30'b0, status}, 32'd0);
        check("rst:rdata_valid", {31'b0, rdata_valid}, 32'd0);
        check("rst:wdata_ready", {31'b0, wdata_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("init:req_ready_low", {31'b0, req_ready}, 32'd0);
        wait_ready(50);
        check("init:csr_writes", csr_writes, 32'd1);
        check("init:csr_value", {24'b0, csr_last}, 32'h0000_00C0);

        // Directed write 0..7 and read 8..15 with a 20-cycle consumer stall
        tx_data.delete();
        for (int i = 0; i < 8; i++) tx_data.push_back(8'(i));
        run_txn("write8", 4'd0, SlaveAddr, 1'b0, 8);

        tx_data.delete();
        for (int i = 8; i < 16; i++) tx_data.push_back(8'(i));
        stall_left = 20;
        run_txn("read8", 4'd0, SlaveAddr, 1'b1, 8);
        check("read8:stall_cycles", stall_seen, 32'd20);

        // Absent slave, address-only probe
        fill_random(4);
        run_txn("nack", 4'd0, 7'h13, 1'b0, 4);
        tx_data.delete();
        run_txn("probe", 4'd0, SlaveAddr, 1'b0, 0);

        // Random transactions, then full-length byte counts
        for (int t = 0; t < 5; t++) begin
            len = int'($urandom_range(1, 12));
            rd  = 1'($urandom_range(0, 1));
            fill_random(len);
            run_txn($sformatf("rand%0d", t), 4'($urandom_range(0, 15)), SlaveAddr, rd, len);
        end
        fill_random(255);
        run_txn("write255", 4'd3, SlaveAddr, 1'b0, 255);
        fill_random(255);
        run_txn("read255", 4'd9, SlaveAddr, 1'b1, 255);

        // irq never arrives: SET_BUS times out, the STOP attempt times out, then done with 11
        irq_en = 0;
        tx_data.delete();
        issue_req(4'd1, SlaveAddr, 1'b0, 2);
        wait_done(2000, cyc);
        check("timeout:status", {30'b0, status}, 32'd3);
        check("timeout:latency_in_range", {31'b0, (cyc >= 200 && cyc < 260)}, 32'd1);
        exp_cmd.delete();
        exp_cmd.push_back(CSetBus);
        exp_cmd.push_back(CStop);
        check_cmds("timeout");
        irq_en = 1;
        @(negedge clk);
        check("timeout:req_ready_after", {31'b0, req_ready}, 32'd1);

        // Reset in the middle of a write
        fill_random(8);
        issue_req(4'd0, SlaveAddr, 1'b0, 8);
        found = 0;
        for (int c = 0; c < 3000 && !found; c++) begin
            @(negedge clk);
            if (wr_log.size() >= 2 && cyc_o) found = 1;
        end
        check("midwr:reached", {31'b0, found}, 32'd1);
        rst = 1'b0;
        #1;
        check("midwr:cyc_o_async", {31'b0, cyc_o}, 32'd0);
        check("midwr:stb_o_async", {31'b0, stb_o}, 32'd0);
        wq.delete();
        wpop = 0;
        repeat (3) @(negedge clk);
        check("midwr:req_ready_in_reset", {31'b0, req_ready}, 32'd0);
        prior = csr_writes;
        rst = 1'b1;
        wait_ready(50);
        check("midwr:csr_rewritten", csr_writes, prior + 1);
        check("midwr:csr_value", {24'b0, csr_last}, 32'h0000_00C0);
        fill_random(3);
        run_txn("after_reset", 4'd2, SlaveAddr, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
